// File: rtl/multi_lane_pred_stage.sv
// multi_lane_pred_stage: gshare PHT + tagged BTB fetch-group predictor with a registered valid/ready output.
// Define PRED_PERF_CNT_EN to add the perf_groups/perf_taken/perf_redirects counters.
module multi_lane_pred_stage #(
  parameter int XLEN = 32,
  parameter int FETCH_WIDTH = 4,
  parameter int PHT_ADDRESS = 9,
  parameter int GHR_SIZE = 9,
  parameter int BTB_INDEX = 6,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                             CLK,
  input  logic                             reset,
  input  logic                             fetch_en,
  input  logic                             out_ready,
  output logic                             out_valid,
  output logic [XLEN-1:0]                  out_pc,
  output logic [FETCH_WIDTH-1:0]           out_lane_valid,
  output logic [FETCH_WIDTH-1:0]           out_taken_oh,
  output logic [XLEN-1:0]                  out_target,
  output logic [FETCH_WIDTH*PHT_ADDRESS-1:0] out_pht_index,
  output logic [GHR_SIZE-1:0]              out_ghr_snap,
  input  logic                             redirect,
  input  logic [XLEN-1:0]                  redirect_pc,
  input  logic [GHR_SIZE-1:0]              redirect_ghr,
  input  logic                             upd_pht_en,
  input  logic [PHT_ADDRESS-1:0]           upd_pht_index,
  input  logic                             upd_taken,
  input  logic                             upd_btb_en,
  input  logic [XLEN-1:0]                  upd_btb_pc,
  input  logic [XLEN-1:0]                  upd_btb_target,
  input  logic                             upd_btb_is_jump
`ifdef PRED_PERF_CNT_EN
  ,
  output logic [31:0]                      perf_groups,
  output logic [31:0]                      perf_taken,
  output logic [31:0]                      perf_redirects
`endif
);
  localparam int TAG_W = XLEN - BTB_INDEX - 2;
  localparam int BTB_N = 1 << BTB_INDEX;
  localparam int PHT_N = 1 << PHT_ADDRESS;
  logic [XLEN-1:0] pc;
  logic [GHR_SIZE-1:0] ghr;
  logic [BTB_N-1:0] btb_valid;
  logic [BTB_N-1:0] btb_jmp;
  logic [TAG_W-1:0] btb_tag [BTB_N];
  logic [XLEN-1:0] btb_tgt [BTB_N];
  logic [1:0] pht [PHT_N];
  logic [FETCH_WIDTH-1:0] hit, jmp, taken, lane_valid, taken_oh;
  logic [XLEN-1:0] lane_tgt [FETCH_WIDTH];
  logic [FETCH_WIDTH*PHT_ADDRESS-1:0] pht_idx;
  logic [XLEN-1:0] target;
  logic [GHR_SIZE-1:0] ghr_next;
  logic found;
  logic adv;
  logic [BTB_INDEX-1:0] btb_widx;
  logic unused_upd;
  assign btb_widx = upd_btb_pc[BTB_INDEX+1:2];
  assign unused_upd = ^upd_btb_pc[1:0];
  for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_lane
    logic [XLEN-1:0] lpc;
    logic [BTB_INDEX-1:0] bidx;
    logic [PHT_ADDRESS-1:0] pidx;
    logic unused_lane;
    assign lpc = pc + XLEN'(4 * i);
    assign bidx = lpc[BTB_INDEX+1:2];
    assign pidx = ghr ^ lpc[PHT_ADDRESS+1:2];
    assign unused_lane = ^lpc[1:0];
    assign hit[i] = btb_valid[bidx] && btb_tag[bidx] == lpc[XLEN-1:BTB_INDEX+2];
    assign jmp[i] = btb_jmp[bidx];
    assign taken[i] = hit[i] && (jmp[i] || pht[pidx][1]);
    assign lane_tgt[i] = btb_tgt[bidx];
    assign pht_idx[i*PHT_ADDRESS +: PHT_ADDRESS] = pidx;
  end
  // Lanes up to and including the first taken one form the group; only conditional hits train the GHR.
  always_comb begin
    found = 1'b0;
    lane_valid = '0;
    taken_oh = '0;
    target = pc + XLEN'(4 * FETCH_WIDTH);
    ghr_next = ghr;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (!found) begin
        lane_valid[i] = 1'b1;
        if (hit[i] && !jmp[i]) ghr_next = {ghr_next[GHR_SIZE-2:0], taken[i]};
        if (taken[i]) begin
          found = 1'b1;
          taken_oh[i] = 1'b1;
          target = lane_tgt[i];
        end
      end
    end
  end
  assign adv = fetch_en && (!out_valid || out_ready) && !redirect;
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
      ghr <= '0;
      out_valid <= 1'b0;
      out_pc <= '0;
      out_lane_valid <= '0;
      out_taken_oh <= '0;
      out_target <= '0;
      out_pht_index <= '0;
      out_ghr_snap <= '0;
    end else if (redirect) begin
      pc <= redirect_pc;
      ghr <= redirect_ghr;
      out_valid <= 1'b0;
    end else if (adv) begin
      pc <= target;
      ghr <= ghr_next;
      out_valid <= 1'b1;
      out_pc <= pc;
      out_lane_valid <= lane_valid;
      out_taken_oh <= taken_oh;
      out_target <= target;
      out_pht_index <= pht_idx;
      out_ghr_snap <= ghr;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < PHT_N; j++) pht[j] <= 2'b01;
    end else if (upd_pht_en) begin
      pht[upd_pht_index] <= upd_taken ? (pht[upd_pht_index] == 2'b11 ? 2'b11 : pht[upd_pht_index] + 2'd1)
                                      : (pht[upd_pht_index] == 2'b00 ? 2'b00 : pht[upd_pht_index] - 2'd1);
    end
  end
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) btb_valid <= '0;
    else if (upd_btb_en) btb_valid[btb_widx] <= 1'b1;
  end
  // Payload needs no reset: it is only observed behind btb_valid.
  always_ff @(posedge CLK) begin
    if (upd_btb_en) begin
      btb_tag[btb_widx] <= upd_btb_pc[XLEN-1:BTB_INDEX+2];
      btb_tgt[btb_widx] <= upd_btb_target;
      btb_jmp[btb_widx] <= upd_btb_is_jump;
    end
  end
`ifdef PRED_PERF_CNT_EN
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      perf_groups <= '0;
      perf_taken <= '0;
      perf_redirects <= '0;
    end else begin
      if (out_valid && out_ready) perf_groups <= perf_groups + 32'd1;
      if (out_valid && out_ready && |out_taken_oh) perf_taken <= perf_taken + 32'd1;
      if (redirect) perf_redirects <= perf_redirects + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_multi_lane_pred_stage.sv
// tb_multi_lane_pred_stage: directed scoreboard bench for multi_lane_pred_stage (default parameters).
module tb_multi_lane_pred_stage;
  logic CLK, reset, fetch_en, out_ready, out_valid;
  logic [31:0] out_pc, out_target, redirect_pc, upd_btb_pc, upd_btb_target;
  logic [3:0] out_lane_valid, out_taken_oh;
  logic [35:0] out_pht_index;
  logic [8:0] out_ghr_snap, redirect_ghr, upd_pht_index;
  logic redirect, upd_pht_en, upd_taken, upd_btb_en, upd_btb_is_jump;
`ifdef PRED_PERF_CNT_EN
  logic [31:0] perf_groups, perf_taken, perf_redirects;
`endif
  typedef struct packed {
    logic [31:0] pc;
    logic [3:0] lv;
    logic [3:0] toh;
    logic [31:0] tgt;
    logic [8:0] ghr;
  } grp_t;
  grp_t sbq[$];
  int n_vec = 0;
  int n_err = 0;
  localparam logic [3:0] F = 4'b1111;
  multi_lane_pred_stage dut (
    .CLK(CLK), .reset(reset), .fetch_en(fetch_en), .out_ready(out_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_lane_valid(out_lane_valid),
    .out_taken_oh(out_taken_oh), .out_target(out_target), .out_pht_index(out_pht_index),
    .out_ghr_snap(out_ghr_snap), .redirect(redirect), .redirect_pc(redirect_pc),
    .redirect_ghr(redirect_ghr), .upd_pht_en(upd_pht_en), .upd_pht_index(upd_pht_index),
    .upd_taken(upd_taken), .upd_btb_en(upd_btb_en), .upd_btb_pc(upd_btb_pc),
    .upd_btb_target(upd_btb_target), .upd_btb_is_jump(upd_btb_is_jump)
`ifdef PRED_PERF_CNT_EN
    , .perf_groups(perf_groups), .perf_taken(perf_taken), .perf_redirects(perf_redirects)
`endif
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [31:0] pc, input logic [3:0] lv, input logic [3:0] toh,
                      input logic [31:0] tgt, input logic [8:0] ghr);
    sbq.push_back('{pc, lv, toh, tgt, ghr});
  endtask
  task automatic pop_chk(input string tag);
    grp_t e;
    if (sbq.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s: scoreboard empty, observed pc %h", tag, out_pc);
    end else begin
      e = sbq.pop_front();
      chk({tag, ".valid"}, 64'(out_valid), 64'd1);
      chk({tag, ".pc"}, 64'(out_pc), 64'(e.pc));
      chk({tag, ".lanes"}, 64'(out_lane_valid), 64'(e.lv));
      chk({tag, ".taken"}, 64'(out_taken_oh), 64'(e.toh));
      chk({tag, ".target"}, 64'(out_target), 64'(e.tgt));
      chk({tag, ".ghr"}, 64'(out_ghr_snap), 64'(e.ghr));
    end
  endtask
  task automatic step();
    @(negedge CLK);
  endtask
  initial begin
    reset = 1'b0; fetch_en = 1'b0; out_ready = 1'b0; redirect = 1'b0;
    redirect_pc = '0; redirect_ghr = '0; upd_pht_en = 1'b0; upd_pht_index = '0;
    upd_taken = 1'b0; upd_btb_en = 1'b0; upd_btb_pc = '0; upd_btb_target = '0;
    upd_btb_is_jump = 1'b0;
    #1;
    chk("rst.valid", 64'(out_valid), 64'd0);
    chk("rst.pc", 64'(out_pc), 64'd0);
    chk("rst.lanes", 64'(out_lane_valid), 64'd0);
    chk("rst.target", 64'(out_target), 64'd0);
    chk("rst.pht", 64'(out_pht_index), 64'd0);
    step(); step();
    reset = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
    push(32'h0, F, 4'b0, 32'h10, 9'h0); step(); pop_chk("seq0");
    chk("seq0.pht", 64'(out_pht_index), 64'({9'd3, 9'd2, 9'd1, 9'd0}));
    push(32'h10, F, 4'b0, 32'h20, 9'h0); step(); pop_chk("seq1");
    push(32'h20, F, 4'b0, 32'h30, 9'h0); step(); pop_chk("seq2");
    upd_btb_en = 1'b1; upd_btb_pc = 32'h18; upd_btb_target = 32'h100; upd_btb_is_jump = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h10; redirect_ghr = 9'h0;
    step(); chk("jmp.drop", 64'(out_valid), 64'd0);
    upd_btb_en = 1'b0; redirect = 1'b0;
    push(32'h10, 4'b0111, 4'b0100, 32'h100, 9'h0); step(); pop_chk("jmp.grp");
    push(32'h100, F, 4'b0, 32'h110, 9'h0); step(); pop_chk("jmp.tgt");
    upd_pht_en = 1'b1; upd_pht_index = 9'd1; upd_taken = 1'b1;
    upd_btb_en = 1'b1; upd_btb_pc = 32'h4; upd_btb_target = 32'h40; upd_btb_is_jump = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h0; redirect_ghr = 9'h0;
    step(); chk("br.train1", 64'(out_valid), 64'd0);
    upd_btb_en = 1'b0;
    step(); chk("br.train2", 64'(out_valid), 64'd0);
    upd_pht_en = 1'b0; redirect = 1'b0;
    push(32'h0, 4'b0011, 4'b0010, 32'h40, 9'h0); step(); pop_chk("br.taken");
    push(32'h40, F, 4'b0, 32'h50, 9'h1); step(); pop_chk("br.ghr1");
    redirect = 1'b1; redirect_pc = 32'h0; redirect_ghr = 9'h1;
    step(); chk("nt.drop", 64'(out_valid), 64'd0);
    redirect = 1'b0;
    push(32'h0, F, 4'b0, 32'h10, 9'h1); step(); pop_chk("nt.grp");
    chk("nt.pht", 64'(out_pht_index), 64'({9'd2, 9'd3, 9'd0, 9'd1}));
    push(32'h10, 4'b0111, 4'b0100, 32'h100, 9'h2); step(); pop_chk("nt.ghr0");
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall.valid", 64'(out_valid), 64'd1);
      chk("stall.pc", 64'(out_pc), 64'h10);
      chk("stall.pht", 64'(out_pht_index), 64'({9'd5, 9'd4, 9'd7, 9'd6}));
    end
    out_ready = 1'b1;
    push(32'h100, F, 4'b0, 32'h110, 9'h2); step(); pop_chk("stall.next");
    push(32'h110, F, 4'b0, 32'h120, 9'h2); step(); pop_chk("stall.next2");
    out_ready = 1'b0;
    step(); chk("rs.hold", 64'(out_pc), 64'h110);
    redirect = 1'b1; redirect_pc = 32'h200; redirect_ghr = 9'h155;
    step(); chk("rs.drop", 64'(out_valid), 64'd0);
    redirect = 1'b0; out_ready = 1'b1;
    push(32'h200, F, 4'b0, 32'h210, 9'h155); step(); pop_chk("rs.grp");
    push(32'h210, F, 4'b0, 32'h220, 9'h155); step(); pop_chk("rs.next");
    #2 reset = 1'b0;
    #1;
    chk("arst.valid", 64'(out_valid), 64'd0);
    chk("arst.pc", 64'(out_pc), 64'd0);
    step(); step();
    reset = 1'b1;
    push(32'h0, F, 4'b0, 32'h10, 9'h0); step(); pop_chk("arst.grp0");
    push(32'h10, F, 4'b0, 32'h20, 9'h0); step(); pop_chk("arst.grp1");
    chk("sb.drain", 64'(sbq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
